phase_seq_ctrl: RTL and testbench
=================================

PHASE_SEQ_CTRL -- requirements
Module: phase_seq_ctrl

Interface
REQ-001 Parameter N_CH, default 2, number of independent phase channels (1..16).
REQ-002 Parameter PHASE_W, default 8, phase accumulator width per channel.
REQ-003 Parameter DIV_W, default 8, rate-divider width per channel.
REQ-004 Parameter STEP_W, default 8, phase step width (STEP_W <= PHASE_W).
REQ-005 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 Port rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 Port en  in  1  global run enable.
REQ-008 Port sync_clr  in  1  synchronous clear of all divider counters and phases.
REQ-009 Port cfg_valid  in  1  config request valid.
REQ-010 Port cfg_ready  out  1  config slot free.
REQ-011 Port cfg_ch  in  max(1,clog2(N_CH))  target channel index.
REQ-012 Port cfg_div  in  DIV_W  divider terminal value; update period = cfg_div+1 cycles.
REQ-013 Port cfg_step  in  STEP_W  phase increment magnitude.
REQ-014 Port cfg_dir  in  1  0 = phase counts up, 1 = down.
REQ-015 Port cfg_en  in  1  1 = channel RUN, 0 = channel IDLE after apply.
REQ-016 Port phase_out  out  N_CH*PHASE_W  registered phases, channel k at bits [k*PHASE_W +: PHASE_W].
REQ-017 Port tick  out  N_CH  registered one-cycle pulse: channel phase updated this cycle.
REQ-018 Port wrap  out  N_CH  registered one-cycle pulse: phase update overflowed (up) or underflowed (down).

Function
REQ-019 Each channel SHALL hold state IDLE or RUN, a divider counter cnt, and registers div, step, dir.
REQ-020 RUN with en=1: if cnt < div, cnt SHALL increment; if cnt == div, cnt SHALL go to 0 and a terminal event occurs.
REQ-021 On a terminal event, phase SHALL become (phase + step) mod 2^PHASE_W (dir=0) or (phase - step) mod 2^PHASE_W (dir=1), step zero-extended.
REQ-022 On a terminal event, tick[k] SHALL be 1 in the cycle the new phase is visible; wrap[k] SHALL be 1 in the same cycle if carry (up) or borrow (down) occurred.
REQ-023 div = 0 SHALL produce a terminal event every cycle; div = 2^DIV_W-1 every 2^DIV_W cycles.
REQ-024 IDLE, or en=0: cnt and phase SHALL hold, tick and wrap SHALL be 0.
REQ-025 cfg_ready SHALL equal NOT pending, where pending is a single registered shadow slot.
REQ-026 Transfer SHALL occur on cycles with cfg_valid=1 and cfg_ready=1; accepted fields SHALL be captured into the slot and pending set next cycle.
REQ-027 A request with cfg_ch >= N_CH SHALL be accepted and discarded (pending not set).
REQ-028 Pending config SHALL apply to its channel in the first cycle after acceptance in which the channel is IDLE, or is RUN with a terminal event.
REQ-029 Apply SHALL load div, step, dir, set state from cfg_en, and clear pending in the same edge; the terminal event of that cycle SHALL use the old step/dir.
REQ-030 Apply SHALL NOT alter phase; cnt SHALL be 0 after apply.
REQ-031 With en=0, pending SHALL still apply to an IDLE target and SHALL wait for a RUN target.
REQ-032 Because cfg_ready is low while pending, a new request SHALL not be accepted in the apply cycle; earliest next acceptance is one cycle after apply.
REQ-033 sync_clr=1 SHALL set cnt and phase of every channel to 0 and force tick/wrap to 0 that cycle; state, div, step, dir SHALL be unaffected.
REQ-034 sync_clr coincident with an apply SHALL load the config and yield cnt=0, phase=0.
REQ-035 Channels SHALL be fully independent except for shared en, sync_clr, and the config slot.

Reset
REQ-036 While rst=0, and on its assertion without waiting for clk: phase=0, cnt=0, all channels IDLE, div=0, step=1, dir=0, pending=0.
REQ-037 Outputs during reset: phase_out=0, tick=0, wrap=0, cfg_ready=1.
REQ-038 Reset asserted mid-operation SHALL discard any pending config.

Verification
REQ-039 Defaults N_CH=2. Config ch0 div=3 step=1 dir=0 en=1, then en=1 -> ch0 tick every 4 cycles; phase 1,2,3,...; wrap at 255->0.
REQ-040 ch1 div=0 step=5 dir=1, from phase 0 -> phase 251,246,... each cycle; wrap on the first update only until next underflow (phase 1 -> 252).
REQ-041 ch0 RUN div=3: send div=1 step=2 mid-period -> cfg_ready low until ch0 terminal event; that update uses step 1; period 2 thereafter with step 2.
REQ-042 cfg_ch=3 with N_CH=2 -> accepted in one cycle; cfg_ready stays 1; no channel changes.
REQ-043 sync_clr pulse with both channels running -> both phases 0 and cnt 0 next edge, no tick that cycle; periods restart from 0.
REQ-044 Deassert-to-assert rst while pending and mid-count -> immediate phase_out=0, cfg_ready=1; after release channels IDLE and ignore en until configured.

Source files
------------

// File: rtl/phase_seq_ctrl.sv
// Multi-channel phase sequencer: per-channel rate divider drives a phase
// accumulator; one shared shadow slot delivers configuration to a channel.
module phase_seq_ctrl #(
  parameter int N_CH    = 2,
  parameter int PHASE_W = 8,
  parameter int DIV_W   = 8,
  parameter int STEP_W  = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [STEP_W-1:0]         cfg_step,
  input  logic                      cfg_dir,
  input  logic                      cfg_en,
  output logic [N_CH*PHASE_W-1:0]   phase_out,
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           wrap,
  output logic [N_CH-1:0]           dbg_state
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_t;

  // Config handshake: a transfer happens on any clock edge where
  // cfg_valid && cfg_ready; cfg_ready is simply the inverse of the slot flag.
  logic              pending;
  logic [CH_W-1:0]   p_ch;
  logic [DIV_W-1:0]  p_div;
  logic [STEP_W-1:0] p_step;
  logic              p_dir;
  logic              p_en;
  logic [N_CH-1:0]   apply;
  logic              accept;
  logic              ch_ok;

  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & ~pending;
  assign ch_ok     = 32'(cfg_ch) < 32'(N_CH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      p_ch    <= '0;
      p_div   <= '0;
      p_step  <= '0;
      p_dir   <= 1'b0;
      p_en    <= 1'b0;
    end else if (|apply) begin
      pending <= 1'b0;
    end else if (accept && ch_ok) begin
      pending <= 1'b1;
      p_ch    <= cfg_ch;
      p_div   <= cfg_div;
      p_step  <= cfg_step;
      p_dir   <= cfg_dir;
      p_en    <= cfg_en;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    st_t                st_q, st_d;
    logic [DIV_W-1:0]   cnt_q, div_q;
    logic [STEP_W-1:0]  step_q;
    logic               dir_q;
    logic [PHASE_W-1:0] phase_q;
    logic               tick_q, wrap_q;
    logic               term;
    logic [PHASE_W:0]   step_x, upd;

    assign term     = (st_q == RUN) && en && (cnt_q == div_q);
    assign apply[k] = pending && (p_ch == CH_W'(k)) && ((st_q == IDLE) || term);
    assign step_x   = (PHASE_W+1)'(step_q);
    // Extra MSB of the widened add/subtract is the carry or borrow.
    assign upd      = dir_q ? ({1'b0, phase_q} - step_x) : ({1'b0, phase_q} + step_x);

    always_comb begin
      st_d = st_q;
      if (apply[k]) st_d = p_en ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= IDLE;
      else      st_q <= st_d;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q   <= '0;
        div_q   <= '0;
        step_q  <= STEP_W'(1);
        dir_q   <= 1'b0;
        phase_q <= '0;
        tick_q  <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        wrap_q <= 1'b0;
        if (sync_clr) begin
          cnt_q   <= '0;
          phase_q <= '0;
        end else if (term) begin
          cnt_q   <= '0;
          phase_q <= upd[PHASE_W-1:0];
          tick_q  <= 1'b1;
          wrap_q  <= upd[PHASE_W];
        end else if (st_q == RUN && en) begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
        // The terminal update above already used the old step/dir.
        if (apply[k]) begin
          div_q  <= p_div;
          step_q <= p_step;
          dir_q  <= p_dir;
          cnt_q  <= '0;
        end
      end
    end

    assign phase_out[k*PHASE_W +: PHASE_W] = phase_q;
    assign tick[k]      = tick_q;
    assign wrap[k]      = wrap_q;
    assign dbg_state[k] = (st_q == RUN);
  end

endmodule

// File: tb/tb_phase_seq_ctrl.sv
// Self-checking bench for phase_seq_ctrl: behavioural channel model feeds a
// tick scoreboard; directed scenarios plus randomized reconfiguration.
module tb_phase_seq_ctrl;
  localparam int PW = 8;
  localparam int PMAX = 1 << PW;
  localparam int EW = 49;

  logic        clk, rst, en, sync_clr, cfg_valid, cfg_ready;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_div, cfg_step;
  logic        cfg_dir, cfg_en;
  logic [15:0] phase_out;
  logic [1:0]  tick, wrap, dbg_state;

  logic        b_cfg_valid, b_cfg_ready;
  logic [1:0]  b_cfg_ch;
  logic [23:0] b_phase_out;
  logic [2:0]  b_tick, b_wrap, b_dbg_state;

  phase_seq_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_step(cfg_step), .cfg_dir(cfg_dir), .cfg_en(cfg_en),
    .phase_out(phase_out), .tick(tick), .wrap(wrap), .dbg_state(dbg_state)
  );

  phase_seq_ctrl #(.N_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(1'b0), .sync_clr(1'b0),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_ch(b_cfg_ch),
    .cfg_div(8'd0), .cfg_step(8'd1), .cfg_dir(1'b0), .cfg_en(1'b1),
    .phase_out(b_phase_out), .tick(b_tick), .wrap(b_wrap), .dbg_state(b_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int m_phase[2], m_cnt[2], m_div[2], m_step[2];
  bit m_dir[2], m_run[2];
  bit m_pend, m_pdir, m_pen;
  int m_pch, m_pdiv, m_pstep;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_cnt[k] = 0; m_div[k] = 0; m_step[k] = 1;
      m_dir[k] = 0; m_run[k] = 0;
    end
    m_pend = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit term[2];
    bit app[2];
    bit acc, w;
    int nv;
    cyc++;
    acc = cfg_valid && !m_pend;
    for (int k = 0; k < 2; k++) begin
      term[k] = m_run[k] && en && (m_cnt[k] == m_div[k]);
      app[k]  = m_pend && (m_pch == k) && (!m_run[k] || term[k]);
    end
    for (int k = 0; k < 2; k++) begin
      if (sync_clr) begin
        m_cnt[k] = 0; m_phase[k] = 0;
      end else if (term[k]) begin
        if (m_dir[k]) begin nv = m_phase[k] - m_step[k]; w = (nv < 0); end
        else          begin nv = m_phase[k] + m_step[k]; w = (nv >= PMAX); end
        m_phase[k] = nv & (PMAX - 1);
        m_cnt[k] = 0;
        exp_q.push_back({8'(k), 32'(cyc), 8'(m_phase[k]), w});
      end else if (m_run[k] && en) begin
        m_cnt[k]++;
      end
      if (app[k]) begin
        m_div[k] = m_pdiv; m_step[k] = m_pstep; m_dir[k] = m_pdir;
        m_run[k] = m_pen; m_cnt[k] = 0;
      end
    end
    if (app[0] || app[1]) m_pend = 0;
    else if (acc && int'(cfg_ch) < 2) begin
      m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
      m_pstep = int'(cfg_step); m_pdir = cfg_dir; m_pen = cfg_en;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          if (tick[k]) begin
            if (exp_q.size() == 0) check($sformatf("tick%0d_unexpected", k), 1, 0);
            else check($sformatf("tick%0d_entry", k),
                       {8'(k), 32'(cyc), phase_out[k*PW +: PW], wrap[k]}, exp_q.pop_front());
          end else if (wrap[k]) begin
            check($sformatf("wrap%0d_without_tick", k), 1, 0);
          end
        end
        check("cfg_ready", cfg_ready, !m_pend);
        check("phase_out", phase_out, {8'(m_phase[1]), 8'(m_phase[0])});
      end
    end
  end

  // driver tasks
  task automatic send_cfg(input int ch, input int div, input int step, input bit dir, input bit cen);
    bit ok;
    ok = 0;
    @(negedge clk);
    cfg_valid = 1; cfg_ch = 1'(ch); cfg_div = 8'(div); cfg_step = 8'(step);
    cfg_dir = dir; cfg_en = cen;
    for (int i = 0; i < 600; i++) begin
      ok = cfg_ready;
      @(negedge clk);
      if (ok) break;
    end
    if (!ok) check("cfg_accept_timeout", 0, 1);
    cfg_valid = 0;
  endtask

  task automatic wait_tick(input int k, input int max_cyc, output bit seen);
    seen = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (tick[k]) begin seen = 1; break; end
    end
    if (!seen) check($sformatf("tick%0d_timeout", k), 0, 1);
  endtask

  initial begin
    bit seen;
    rst = 0; en = 0; sync_clr = 0; cfg_valid = 0; cfg_ch = 0;
    cfg_div = 0; cfg_step = 0; cfg_dir = 0; cfg_en = 0;
    b_cfg_valid = 0; b_cfg_ch = 0;
    #3;
    check("rst_phase", phase_out, 0);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst = 1;

    // out-of-range channel is swallowed; in-range one applies to idle channel
    @(negedge clk); b_cfg_valid = 1; b_cfg_ch = 2'd3;
    @(negedge clk); b_cfg_valid = 0;
    check("oor_ready", b_cfg_ready, 1);
    check("oor_state", b_dbg_state, 0);
    check("oor_phase", b_phase_out, 0);
    b_cfg_valid = 1; b_cfg_ch = 2'd2;
    @(negedge clk); b_cfg_valid = 0;
    check("inr_pending", b_cfg_ready, 0);
    @(negedge clk);
    check("inr_applied", b_cfg_ready, 1);
    check("inr_state", b_dbg_state, 3'b100);

    // ch0 counts up every 4 cycles through a full wrap
    send_cfg(0, 3, 1, 0, 1);
    en = 1;
    wait_tick(0, 20, seen);
    check("ch0_first_phase", phase_out[7:0], 8'd1);
    check("ch0_first_wrap", wrap[0], 0);
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (wrap[0]) begin seen = 1; break; end
    end
    check("ch0_wrap_seen", seen, 1);
    check("ch0_wrap_phase", phase_out[7:0], 8'd0);

    // ch1 counts down by 5 every cycle
    send_cfg(1, 0, 5, 1, 1);
    wait_tick(1, 10, seen);
    check("ch1_first_phase", phase_out[15:8], 8'd251);
    check("ch1_first_wrap", wrap[1], 1);
    repeat (70) @(negedge clk);

    // reconfigure ch0 mid-period: slot stays busy until its terminal event
    repeat (2) @(negedge clk);
    send_cfg(0, 1, 2, 0, 1);
    check("midcfg_busy", cfg_ready, 0);
    repeat (30) @(negedge clk);

    // synchronous clear with both channels running
    sync_clr = 1;
    @(negedge clk); sync_clr = 0;
    check("clr_phase", phase_out, 0);
    check("clr_tick", tick, 0);
    check("clr_wrap", wrap, 0);
    repeat (12) @(negedge clk);

    // clear coincident with an apply to ch1
    send_cfg(1, 2, 3, 0, 1);
    sync_clr = 1;
    @(negedge clk); sync_clr = 0;
    check("clr_apply_phase1", phase_out[15:8], 8'd0);
    repeat (12) @(negedge clk);

    // en low: pending waits for the running target
    en = 0;
    send_cfg(0, 4, 7, 1, 1);
    repeat (10) @(negedge clk);
    check("en0_waits", cfg_ready, 0);
    en = 1;
    repeat (20) @(negedge clk);

    // randomized reconfiguration with en gaps and clears
    for (int it = 0; it < 14; it++) begin
      en = 1; sync_clr = 0;
      send_cfg($urandom_range(0, 1), $urandom_range(0, 9), $urandom_range(0, 255),
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) begin
        @(negedge clk);
        en = $urandom_range(0, 4) != 0;
        sync_clr = $urandom_range(0, 15) == 0;
      end
      @(negedge clk); en = 1; sync_clr = 0;
    end
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    // reset mid-count with config pending
    send_cfg(0, 7, 1, 0, 1);
    send_cfg(0, 3, 1, 0, 1);
    check("pre_rst_pending", cfg_ready, 0);
    #2 rst = 0;
    #1;
    check("arst_phase", phase_out, 0);
    check("arst_ready", cfg_ready, 1);
    check("arst_tick", tick, 0);
    @(negedge clk); rst = 1; en = 1;
    repeat (20) @(negedge clk);
    check("post_rst_state", dbg_state, 0);
    check("post_rst_phase", phase_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    check("global_timeout", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
